mem_ctrl_arbiter: RTL and testbench

Sequences and shares the single byte-wide RAM port between the instruction fetcher (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes). It latches one-cycle request pulses, arbitrates round-robin, and serializes each access into byte transfers. It returns little-endian assembled words with a one-cycle ready pulse, and drops fetches and loads on ROB rollback.

---
 rtl/mem_ctrl_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_ctrl_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter: shares one byte-wide RAM port between instruction fetch and the
// load/store buffer, serializing word accesses into little-endian byte transfers.
module mem_ctrl_arbiter #(
  parameter logic [1:0] IO_MASK = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_request_in,
  input  logic [31:0] if_address_in,
  output logic        if_ready_out,
  output logic [31:0] if_instruction_out,
  input  logic        lsb_request_in,
  input  logic        lsb_write_in,
  input  logic [31:0] lsb_address_in,
  input  logic [2:0]  lsb_size_in,
  input  logic [31:0] lsb_data_in,
  output logic        lsb_ready_out,
  output logic [31:0] lsb_data_out,
  input  logic        rob_rollback_in,
  input  logic [7:0]  mem_din_in,
  output logic [7:0]  mem_dout_out,
  output logic [31:0] mem_a_out,
  output logic        mem_wr_out,
  input  logic        io_buffer_full_in
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state;

  logic        pend_if, pend_lsb;
  logic [31:0] pi_addr;
  logic [31:0] pl_addr, pl_data;
  logic [2:0]  pl_size;
  logic        pl_write;

  logic        cur_if;
  logic        last_grant_if;
  logic        cur_io;
  logic [2:0]  cnt;
  logic [1:0]  last;
  logic [31:0] wdata, rbuf;

  logic        if_new, lsb_new, if_avail, lsb_keep, lsb_avail;
  logic        grant_if, grant_lsb;
  logic [31:0] sel_if_addr, sel_lsb_addr, sel_lsb_data;
  logic [2:0]  sel_lsb_size;
  logic        sel_lsb_write;
  logic [31:0] g_addr;
  logic [1:0]  g_last;
  logic        g_write, g_io;
  logic [1:0]  cap_idx;
  logic [31:0] rd_word;

  function automatic logic [1:0] size_last(input logic [2:0] sz);
    case (sz)
      3'd1:    return 2'd0;
      3'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    // A pulse is ignored while its requester is pending or in service; rollback drops reads.
    if_new  = if_request_in && !rob_rollback_in && !pend_if && !(state != IDLE && cur_if);
    lsb_new = lsb_request_in && !(rob_rollback_in && !lsb_write_in) && !pend_lsb &&
              !(state != IDLE && !cur_if);
    if_avail  = (pend_if && !rob_rollback_in) || if_new;
    lsb_keep  = pend_lsb && !(rob_rollback_in && !pl_write);
    lsb_avail = lsb_keep || lsb_new;

    sel_if_addr   = pend_if  ? pi_addr  : if_address_in;
    sel_lsb_addr  = pend_lsb ? pl_addr  : lsb_address_in;
    sel_lsb_data  = pend_lsb ? pl_data  : lsb_data_in;
    sel_lsb_size  = pend_lsb ? pl_size  : lsb_size_in;
    sel_lsb_write = pend_lsb ? pl_write : lsb_write_in;

    grant_if  = 1'b0;
    grant_lsb = 1'b0;
    if (state == IDLE) begin
      if (if_avail && lsb_avail) begin
        grant_if  = !last_grant_if;
        grant_lsb = last_grant_if;
      end else begin
        grant_if  = if_avail;
        grant_lsb = lsb_avail;
      end
    end

    g_addr  = grant_if ? sel_if_addr : sel_lsb_addr;
    g_last  = grant_if ? 2'd3 : size_last(sel_lsb_size);
    g_write = grant_lsb && sel_lsb_write;
    g_io    = (g_addr[17:16] == IO_MASK);

    // Byte arriving now belongs to the address issued one cycle earlier.
    cap_idx = cnt[1:0] - 2'd1;
    rd_word = rbuf;
    rd_word[{cap_idx, 3'b000} +: 8] = mem_din_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      pend_if            <= 1'b0;
      pend_lsb           <= 1'b0;
      pi_addr            <= '0;
      pl_addr            <= '0;
      pl_data            <= '0;
      pl_size            <= '0;
      pl_write           <= 1'b0;
      cur_if             <= 1'b0;
      last_grant_if      <= 1'b1;
      cur_io             <= 1'b0;
      cnt                <= '0;
      last               <= '0;
      wdata              <= '0;
      rbuf               <= '0;
      if_ready_out       <= 1'b0;
      if_instruction_out <= '0;
      lsb_ready_out      <= 1'b0;
      lsb_data_out       <= '0;
      mem_dout_out       <= '0;
      mem_a_out          <= '0;
      mem_wr_out         <= 1'b0;
    end else begin
      if_ready_out  <= 1'b0;
      lsb_ready_out <= 1'b0;
      pend_if       <= if_avail && !grant_if;
      pend_lsb      <= lsb_avail && !grant_lsb;
      if (if_new) pi_addr <= if_address_in;
      if (lsb_new) begin
        pl_addr  <= lsb_address_in;
        pl_data  <= lsb_data_in;
        pl_size  <= lsb_size_in;
        pl_write <= lsb_write_in;
      end

      case (state)
        IDLE: begin
          if (grant_if || grant_lsb) begin
            cur_if        <= grant_if;
            last_grant_if <= grant_if;
            cur_io        <= g_io;
            last          <= g_last;
            cnt           <= '0;
            rbuf          <= '0;
            mem_a_out     <= g_addr;
            wdata         <= sel_lsb_data;
            if (g_write) begin
              state        <= WRITE;
              mem_dout_out <= sel_lsb_data[7:0];
              mem_wr_out   <= !(g_io && io_buffer_full_in);
            end else begin
              state      <= READ;
              mem_wr_out <= 1'b0;
            end
          end
        end

        READ: begin
          if (rob_rollback_in) begin
            state      <= IDLE;
            mem_wr_out <= 1'b0;
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt < {1'b0, last}) mem_a_out <= mem_a_out + 32'd1;
            if (cnt != 3'd0) rbuf <= rd_word;
            if (cnt == {1'b0, last} + 3'd1) begin
              state <= IDLE;
              if (cur_if) begin
                if_ready_out       <= 1'b1;
                if_instruction_out <= rd_word;
              end else begin
                lsb_ready_out <= 1'b1;
                lsb_data_out  <= rd_word;
              end
            end
          end
        end

        WRITE: begin
          // mem_wr_out low here means the current byte is still stalled on the I/O buffer.
          if (mem_wr_out) begin
            if (cnt[1:0] == last) begin
              state         <= IDLE;
              mem_wr_out    <= 1'b0;
              lsb_ready_out <= 1'b1;
            end else begin
              cnt          <= cnt + 3'd1;
              mem_a_out    <= mem_a_out + 32'd1;
              mem_dout_out <= wdata[15:8];
              wdata        <= {8'h00, wdata[31:8]};
              mem_wr_out   <= !(cur_io && io_buffer_full_in);
            end
          end else begin
            mem_wr_out <= !(cur_io && io_buffer_full_in);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed bench for mem_ctrl_arbiter: a byte RAM model feeds reads, and scoreboards
// hold the expected ready pulses and RAM writes with the cycle each must appear in.
module tb_mem_ctrl_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_request_in = 1'b0;
  logic [31:0] if_address_in = '0;
  logic        if_ready_out;
  logic [31:0] if_instruction_out;
  logic        lsb_request_in = 1'b0;
  logic        lsb_write_in = 1'b0;
  logic [31:0] lsb_address_in = '0;
  logic [2:0]  lsb_size_in = '0;
  logic [31:0] lsb_data_in = '0;
  logic        lsb_ready_out;
  logic [31:0] lsb_data_out;
  logic        rob_rollback_in = 1'b0;
  logic [7:0]  mem_din_in = '0;
  logic [7:0]  mem_dout_out;
  logic [31:0] mem_a_out;
  logic        mem_wr_out;
  logic        io_buffer_full_in = 1'b0;

  typedef struct { logic [31:0] data; int cyc; bit chk_data; } rdy_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;

  rdy_t if_q[$];
  rdy_t lsb_q[$];
  wr_t  wr_q[$];
  logic [7:0] ram [bit [31:0]];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t0;

  mem_ctrl_arbiter #(.IO_MASK(2'b11)) dut (
    .clk(clk), .rst(rst),
    .if_request_in(if_request_in), .if_address_in(if_address_in),
    .if_ready_out(if_ready_out), .if_instruction_out(if_instruction_out),
    .lsb_request_in(lsb_request_in), .lsb_write_in(lsb_write_in),
    .lsb_address_in(lsb_address_in), .lsb_size_in(lsb_size_in),
    .lsb_data_in(lsb_data_in), .lsb_ready_out(lsb_ready_out),
    .lsb_data_out(lsb_data_out), .rob_rollback_in(rob_rollback_in),
    .mem_din_in(mem_din_in), .mem_dout_out(mem_dout_out),
    .mem_a_out(mem_a_out), .mem_wr_out(mem_wr_out),
    .io_buffer_full_in(io_buffer_full_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // RAM returns the byte for the address presented during the previous cycle.
  always @(posedge clk) mem_din_in <= ram.exists(mem_a_out) ? ram[mem_a_out] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    rdy_t e;
    wr_t  w;
    if (!rst) begin
      if (if_ready_out) begin
        chk("if_ready_expected", 32'(if_q.size() != 0), 32'd1);
        if (if_q.size() != 0) begin
          e = if_q.pop_front();
          chk("if_ready_cycle", cyc, e.cyc);
          chk("if_instruction", if_instruction_out, e.data);
        end
      end
      if (lsb_ready_out) begin
        chk("lsb_ready_expected", 32'(lsb_q.size() != 0), 32'd1);
        if (lsb_q.size() != 0) begin
          e = lsb_q.pop_front();
          chk("lsb_ready_cycle", cyc, e.cyc);
          if (e.chk_data) chk("lsb_data", lsb_data_out, e.data);
        end
      end
      if (mem_wr_out) begin
        chk("write_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          chk("write_cycle", cyc, w.cyc);
          chk("write_addr", mem_a_out, w.addr);
          chk("write_data", {24'h0, mem_dout_out}, {24'h0, w.data});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (if_q.size() + lsb_q.size() + wr_q.size()) != 0; i++) step();
    wait_n(3);
    chk("queues_drained", if_q.size() + lsb_q.size() + wr_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h204] = 8'hF0; ram[32'h205] = 8'h77; ram[32'h206] = 8'h12; ram[32'h207] = 8'h34;

    wait_n(3);
    chk("rst_if_ready", if_ready_out, 32'd0);
    chk("rst_if_instruction", if_instruction_out, 32'd0);
    chk("rst_lsb_ready", lsb_ready_out, 32'd0);
    chk("rst_lsb_data", lsb_data_out, 32'd0);
    chk("rst_mem_a", mem_a_out, 32'd0);
    chk("rst_mem_dout", mem_dout_out, 32'd0);
    chk("rst_mem_wr", mem_wr_out, 32'd0);
    rst = 1'b0;
    step();

    // First tie after reset: LSB wins, fetch follows one idle cycle later.
    t0 = cyc;
    lsb_q.push_back('{32'h000077F0, t0 + 4, 1'b1});
    if_q.push_back('{32'h00000513, t0 + 10, 1'b1});
    if_request_in = 1'b1; if_address_in = 32'h100;
    lsb_request_in = 1'b1; lsb_write_in = 1'b0; lsb_address_in = 32'h204; lsb_size_in = 3'd2;
    step();
    if_request_in = 1'b0; lsb_request_in = 1'b0;
    chk("tie1_lsb_addr", mem_a_out, 32'h204);
    wait_n(4);
    chk("tie1_fetch_grant_addr", mem_a_out, 32'h100);
    drain();

    // Byte load, zero-extended even though the next RAM byte is nonzero.
    t0 = cyc;
    lsb_q.push_back('{32'h000000F0, t0 + 3, 1'b1});
    lsb_request_in = 1'b1; lsb_write_in = 1'b0; lsb_address_in = 32'h204; lsb_size_in = 3'd1;
    step();
    lsb_request_in = 1'b0;
    drain();

    // Repeat tie with LSB granted last: fetch wins; size 3 behaves as 4.
    t0 = cyc;
    if_q.push_back('{32'h00000513, t0 + 6, 1'b1});
    lsb_q.push_back('{32'h341277F0, t0 + 12, 1'b1});
    if_request_in = 1'b1; if_address_in = 32'h100;
    lsb_request_in = 1'b1; lsb_write_in = 1'b0; lsb_address_in = 32'h204; lsb_size_in = 3'd3;
    step();
    if_request_in = 1'b0; lsb_request_in = 1'b0;
    chk("tie2_fetch_addr", mem_a_out, 32'h100);
    drain();

    // Fetch alone: addresses 0x100..0x103 in cycles 1..4.
    t0 = cyc;
    if_q.push_back('{32'h00000513, t0 + 6, 1'b1});
    if_request_in = 1'b1; if_address_in = 32'h100;
    for (int k = 0; k < 4; k++) begin
      step();
      if_request_in = 1'b0;
      chk("fetch_addr", mem_a_out, 32'h100 + 32'(k));
    end
    drain();

    // I/O store stalled: buffer-full is seen at the edges that would issue cycles 1..3.
    t0 = cyc;
    wr_q.push_back('{32'h00030000, 8'h41, t0 + 4});
    lsb_q.push_back('{32'h0, t0 + 5, 1'b0});
    lsb_request_in = 1'b1; lsb_write_in = 1'b1; lsb_address_in = 32'h00030000;
    lsb_size_in = 3'd1; lsb_data_in = 32'h12345641; io_buffer_full_in = 1'b1;
    step();
    lsb_request_in = 1'b0;
    chk("stall_wr_c1", mem_wr_out, 32'd0);
    step();
    chk("stall_wr_c2", mem_wr_out, 32'd0);
    step();
    chk("stall_wr_c3", mem_wr_out, 32'd0);
    io_buffer_full_in = 1'b0;
    drain();

    // Rollback in cycle 3 of a fetch; a new fetch in cycle 4 completes in cycle 10.
    t0 = cyc;
    if_q.push_back('{32'h341277F0, t0 + 10, 1'b1});
    if_request_in = 1'b1; if_address_in = 32'h100;
    step();
    if_request_in = 1'b0;
    wait_n(2);
    rob_rollback_in = 1'b1;
    step();
    rob_rollback_in = 1'b0;
    chk("rollback_wr_low", mem_wr_out, 32'd0);
    if_request_in = 1'b1; if_address_in = 32'h204;
    step();
    if_request_in = 1'b0;
    drain();

    // Rollback during a 4-byte store leaves the store intact.
    t0 = cyc;
    wr_q.push_back('{32'h400, 8'hEF, t0 + 1});
    wr_q.push_back('{32'h401, 8'hBE, t0 + 2});
    wr_q.push_back('{32'h402, 8'hAD, t0 + 3});
    wr_q.push_back('{32'h403, 8'hDE, t0 + 4});
    lsb_q.push_back('{32'h0, t0 + 5, 1'b0});
    lsb_request_in = 1'b1; lsb_write_in = 1'b1; lsb_address_in = 32'h400;
    lsb_size_in = 3'd4; lsb_data_in = 32'hDEADBEEF;
    step();
    lsb_request_in = 1'b0;
    step();
    rob_rollback_in = 1'b1;
    step();
    rob_rollback_in = 1'b0;
    drain();

    // Fetch pulse coinciding with rollback is dropped: no grant, no ready.
    if_request_in = 1'b1; if_address_in = 32'h100; rob_rollback_in = 1'b1;
    step();
    if_request_in = 1'b0; rob_rollback_in = 1'b0;
    wait_n(8);
    chk("dropped_fetch_addr", mem_a_out, 32'h403);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
